// File: rtl/fpu_recode_sched.sv
`default_nettype none
// =============================================================================
// fpu_recode_sched : round-robin, credit-gated issue into the fixed-latency
//                    FP recode pipeline, with an in-order tagged result FIFO.
// Revision: 1.0
// =============================================================================
module fpu_recode_sched #(
  parameter int LAT               = 2,
  parameter int TAG_W             = 5,
  parameter int QDEPTH            = 4,
  parameter int FPR_WIDTH         = 64,
  parameter int FPR_RECODED_WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_val,
  output logic                         req0_rdy,
  input  logic [TAG_W-1:0]             req0_tag,
  input  logic [FPR_WIDTH-1:0]         req0_data,
  input  logic                         req1_val,
  output logic                         req1_rdy,
  input  logic [TAG_W-1:0]             req1_tag,
  input  logic [FPR_WIDTH-1:0]         req1_data,
  output logic [FPR_WIDTH-1:0]         pipe_in,
  input  logic [FPR_RECODED_WIDTH-1:0] pipe_result,
  output logic                         wb_val,
  input  logic                         wb_rdy,
  output logic [TAG_W-1:0]             wb_tag,
  output logic [FPR_RECODED_WIDTH-1:0] wb_data
);
  localparam int                 c_PTR_W  = $clog2(QDEPTH);
  localparam int                 c_CNT_W  = $clog2(QDEPTH + LAT + 1);
  localparam logic [c_CNT_W-1:0] c_QDEPTH = c_CNT_W'(QDEPTH);

  logic [LAT-1:0]               sh_val_q;
  logic [TAG_W-1:0]             sh_tag_q [LAT];
  logic                         last_q, last_d;
  logic [c_PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]           occ_q, occ_d;
  logic [TAG_W-1:0]             fifo_tag_q  [QDEPTH];
  logic [FPR_RECODED_WIDTH-1:0] fifo_data_q [QDEPTH];

  logic [c_CNT_W-1:0] w_inflight;
  logic               w_credit_ok, w_grant0, w_grant1, w_grant, w_push, w_pop;
  logic [TAG_W-1:0]   w_grant_tag;

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      w_inflight = w_inflight + c_CNT_W'(sh_val_q[k]);
    end
  end

  // Credits count every slot already promised to a result; a pop this cycle
  // only frees a credit once occ_q has actually dropped.
  assign w_credit_ok = (occ_q + w_inflight) < c_QDEPTH;

  // last_q == 1 means port 1 was granted last, so port 0 wins a tie.
  assign w_grant0    = w_credit_ok & req0_val & (~req1_val | last_q);
  assign w_grant1    = w_credit_ok & req1_val & (~req0_val | ~last_q);
  assign w_grant     = w_grant0 | w_grant1;
  assign w_grant_tag = w_grant1 ? req1_tag : req0_tag;

  assign req0_rdy = w_grant0;
  assign req1_rdy = w_grant1;
  assign pipe_in  = w_grant1 ? req1_data : req0_data;

  assign w_push  = sh_val_q[LAT-1];
  assign wb_val  = (occ_q != '0);
  assign w_pop   = wb_val & wb_rdy;
  assign wb_tag  = fifo_tag_q[rd_ptr_q];
  assign wb_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    last_d = last_q;
    if (w_grant0) begin
      last_d = 1'b0;
    end else if (w_grant1) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + c_CNT_W'(1);
      2'b01:   occ_d = occ_q - c_CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_val_q <= '0;
      last_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      sh_val_q[0] <= w_grant;
      for (int k = 1; k < LAT; k++) begin
        sh_val_q[k] <= sh_val_q[k-1];
      end
      last_q <= last_d;
      occ_q  <= occ_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
    end
  end

  // Datapath storage carries no reset; validity lives in sh_val_q and occ_q.
  always_ff @(posedge clk) begin
    sh_tag_q[0] <= w_grant_tag;
    for (int k = 1; k < LAT; k++) begin
      sh_tag_q[k] <= sh_tag_q[k-1];
    end
    if (w_push) begin
      fifo_tag_q[wr_ptr_q]  <= sh_tag_q[LAT-1];
      fifo_data_q[wr_ptr_q] <= pipe_result;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && (occ_q == c_QDEPTH) && !w_pop));
    end
  end
`endif

endmodule
`default_nettype wire
